// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - funct3 codes, owner encodings and response tag for mem_arbiter
// Ports: none (package)
package mem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Everything the response cycle needs to know about the grant one cycle earlier.
    typedef struct packed {
        logic       valid;
        logic       owner;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       we;
        logic       err;
    } resp_tag_t;

    // Byte-lane write enables for a legal store; illegal codes enable nothing.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Fetches are always word accesses; halves need addr[0] clear, words addr[1:0] clear.
    function automatic logic is_misaligned(input logic owner, input logic [2:0] f3,
                                           input logic [1:0] off);
        if (owner == OWN_IF) return off != 2'b00;
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational sub-word lane placement (store) and extraction/extension (load)
// Ports:
//   store    in   1 = replicate store data into lanes, 0 = extract load data
//   funct3   in   RISC-V access size/sign code
//   off      in   byte offset addr[1:0] (load direction only)
//   data_in  in   LSB-aligned store data, or raw RAM word
//   data_out out  lane-placed store data, or extended load value (0 on error)
//   err      out  funct3 not legal for the selected direction
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (off)
            2'd0:    sel_byte = data_in[7:0];
            2'd1:    sel_byte = data_in[15:8];
            2'd2:    sel_byte = data_in[23:16];
            default: sel_byte = data_in[31:24];
        endcase
        sel_half = off[1] ? data_in[31:16] : data_in[15:0];

        data_out = '0;
        err      = 1'b0;
        if (store) begin
            // Stores replicate the value into every lane; the byte enables pick the real target.
            case (funct3)
                F3_B:    data_out = {4{data_in[7:0]}};
                F3_H:    data_out = {2{data_in[15:0]}};
                F3_W:    data_out = data_in;
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:    data_out = {{24{sel_byte[7]}}, sel_byte};
                F3_BU:   data_out = {24'd0, sel_byte};
                F3_H:    data_out = {{16{sel_half[15]}}, sel_half};
                F3_HU:   data_out = {16'd0, sel_half};
                F3_W:    data_out = data_in;
                default: err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch / load-store) arbiter for one port of a byte-enabled data RAM
// Optional feature macro: MEM_ARB_MISALIGN_CHK_EN (misaligned accesses granted without writing, flagged in response)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_valid/ready/addr       fetch request handshake and byte address
//   if_resp_valid/data            fetch response, one cycle after grant
//   d_req_valid/ready/we/funct3/addr/wdata   load/store request
//   d_resp_valid/data/err         load data or store acknowledge, one cycle after grant
//   ram_addr/we/wdata             RAM address, byte-lane enables, lane-placed data
//   ram_rdata                     RAM read data, one cycle after ram_addr
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_IF_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [2:0]  d_req_funct3,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] MAX_WAIT = 4'(MAX_IF_WAIT);

    logic [3:0]  if_wait_cnt;
    logic        if_gnt;
    logic        d_gnt;
    logic        mis_g;
    logic [31:0] ram_addr_q;
    resp_tag_t   tag_d;
    resp_tag_t   tag_q;
    logic [31:0] st_data;
    logic        st_err;
    logic [31:0] ld_data;
    logic        ld_err;
    logic        d_err_full;

    // D wins contention until IF has been refused MAX_IF_WAIT cycles in a row.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req_valid && d_req_valid) begin
                if (if_wait_cnt == MAX_WAIT) if_gnt = 1'b1;
                else                         d_gnt  = 1'b1;
            end else begin
                if_gnt = if_req_valid;
                d_gnt  = d_req_valid;
            end
        end
    end

    assign if_req_ready = if_gnt;
    assign d_req_ready  = d_gnt;

    always_comb begin
`ifdef MEM_ARB_MISALIGN_CHK_EN
        if (if_gnt)     mis_g = is_misaligned(OWN_IF, F3_W, if_req_addr[1:0]);
        else if (d_gnt) mis_g = is_misaligned(OWN_D, d_req_funct3, d_req_addr[1:0]);
        else            mis_g = 1'b0;
`else
        mis_g = 1'b0;
`endif
    end

    mem_lane_align u_store_align (
        .store    (1'b1),
        .funct3   (d_req_funct3),
        .off      (d_req_addr[1:0]),
        .data_in  (d_req_wdata),
        .data_out (st_data),
        .err      (st_err)
    );

    // ram_addr holds its last value when nothing is granted so the RAM read port stays quiet.
    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 4'b0000;
        ram_wdata = 32'd0;
        if (if_gnt) begin
            ram_addr = if_req_addr;
        end else if (d_gnt) begin
            ram_addr = d_req_addr;
            if (d_req_we) begin
                ram_wdata = st_data;
                if (!st_err && !mis_g) ram_we = store_be(d_req_funct3, d_req_addr[1:0]);
            end
        end
    end

    always_comb begin
        tag_d = '0;
        if (if_gnt) begin
            tag_d.valid  = 1'b1;
            tag_d.owner  = OWN_IF;
            tag_d.funct3 = F3_W;
            tag_d.off    = if_req_addr[1:0];
            tag_d.err    = mis_g;
        end else if (d_gnt) begin
            tag_d.valid  = 1'b1;
            tag_d.owner  = OWN_D;
            tag_d.funct3 = d_req_funct3;
            tag_d.off    = d_req_addr[1:0];
            tag_d.we     = d_req_we;
            tag_d.err    = mis_g | (d_req_we & st_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_cnt <= 4'd0;
            tag_q       <= '0;
            ram_addr_q  <= 32'd0;
        end else begin
            tag_q      <= tag_d;
            ram_addr_q <= ram_addr;
            if (if_req_valid && !if_gnt) begin
                if (if_wait_cnt != MAX_WAIT) if_wait_cnt <= if_wait_cnt + 4'd1;
            end else begin
                if_wait_cnt <= 4'd0;
            end
        end
    end

    mem_lane_align u_load_align (
        .store    (1'b0),
        .funct3   (tag_q.funct3),
        .off      (tag_q.off),
        .data_in  (ram_rdata),
        .data_out (ld_data),
        .err      (ld_err)
    );

    // Gating with rst drops a response that is in flight when reset arrives.
    assign if_resp_valid = !rst && tag_q.valid && (tag_q.owner == OWN_IF);
    assign d_resp_valid  = !rst && tag_q.valid && (tag_q.owner == OWN_D);
    assign d_err_full    = tag_q.err | (!tag_q.we & ld_err);

    assign if_resp_data = (if_resp_valid && !tag_q.err) ? ram_rdata : 32'd0;
    assign d_resp_err   = d_resp_valid & d_err_full;
    assign d_resp_data  = (d_resp_valid && !tag_q.we && !d_err_full) ? ld_data : 32'd0;

endmodule
